adder_32: RTL and testbench

- Registered 32-bit unsigned adder. Produces sum and carry-out of two operands.
- Datapath building block for the RV32 ALU/PC path.
- Combinational core is a two-level carry-lookahead adder built from 4-bit blocks.
- Result is captured in output registers on every rising clock edge.

---
 rtl/adder_pkg.sv | 35 +++
 rtl/cla_block.sv | 36 +++
 rtl/adder_32.sv | 62 ++++++
 tb/tb_adder_32.sv | 120 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, types and carry-lookahead helper for the adder datapath.
// Imported by cla_block and adder_32.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int CLA_BLOCK   = 4;
    localparam int NUM_BLOCKS  = ADDER_WIDTH / CLA_BLOCK;

    typedef logic [ADDER_WIDTH-1:0] word_t;

    // Carry into position n, as a flat sum of products:
    // cin & p[0..n-1]  |  OR over j<n of g[j] & p[j+1..n-1].
    function automatic logic lookahead(
        input word_t g,
        input word_t p,
        input logic  cin,
        input int    n
    );
        logic carry;
        logic term;
        carry = cin;
        for (int k = 0; k < n; k++) begin
            carry = carry & p[k];
        end
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int k = j + 1; k < n; k++) begin
                term = term & p[k];
            end
            carry = carry | term;
        end
        return carry;
    endfunction

endpackage

// File: rtl/cla_block.sv
// One carry-lookahead block: internal carries, sum bits,
// and group generate/propagate for the next lookahead level.
module cla_block
    import adder_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             grp_g,
    output logic             grp_p
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    // Group terms never depend on cin, so the upper level has no loop.
    assign grp_g = lookahead(word_t'(g), word_t'(p), 1'b0, BLOCK);
    assign grp_p = &p;

    always_comb begin
        carry = '0;
        for (int i = 0; i < BLOCK; i++) begin
            carry[i] = lookahead(word_t'(g), word_t'(p), cin, i);
        end
    end

    assign sum = p ^ carry;

endmodule

// File: rtl/adder_32.sv
// Registered unsigned adder, {c, s} = a + b, one cycle latency.
// Two-level carry lookahead: per-block CLA plus a group unit.
module adder_32
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int NB = WIDTH / BLOCK;

    logic [NB-1:0]    blk_g;
    logic [NB-1:0]    blk_p;
    logic [NB-1:0]    blk_cin;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_d;
    logic             c_q;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla_block #(
            .BLOCK (BLOCK)
        ) u_cla (
            .a     (a[k*BLOCK +: BLOCK]),
            .b     (b[k*BLOCK +: BLOCK]),
            .cin   (blk_cin[k]),
            .sum   (s_d[k*BLOCK +: BLOCK]),
            .grp_g (blk_g[k]),
            .grp_p (blk_p[k])
        );
    end

    // Every block carry-in comes straight from {G, P}; no inter-block ripple.
    always_comb begin
        blk_cin = '0;
        for (int k = 0; k < NB; k++) begin
            blk_cin[k] = lookahead(word_t'(blk_g), word_t'(blk_p), 1'b0, k);
        end
        c_d = lookahead(word_t'(blk_g), word_t'(blk_p), 1'b0, NB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign s = s_q;
    assign c = c_q;

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: directed corner cases plus random pairs
// against a 33-bit arithmetic reference, checked by a separate monitor.
module tb_adder_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;

    int          checks;
    int          errors;
    logic [32:0] exp_q[$];
    string       name_q[$];
    logic [32:0] exp_v;
    string       exp_n;

    adder_32 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair for the next rising edge and record
    // what the outputs must show right after that edge.
    task automatic drive(input logic r, input logic [31:0] av,
                         input logic [31:0] bv, input string nm);
        logic [32:0] ref_sum;
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        ref_sum = r ? 33'd0 : ({1'b0, av} + {1'b0, bv});
        exp_q.push_back(ref_sum);
        name_q.push_back(nm);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                exp_n = name_q.pop_front();
                checks++;
                if ($isunknown({c, s}) || {c, s} !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got c=%0b s=%08h, want c=%0b s=%08h",
                             exp_n, c, s, exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rr;
        int          waited;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = 32'h0;
        b   = 32'h0;

        drive(1'b1, 32'h1234_5678, 32'h0000_0001, "reset_0");
        drive(1'b1, 32'h1234_5678, 32'h0000_0001, "reset_1");
        drive(1'b0, 32'h0000_0000, 32'h0000_4000, "single_bit");
        drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "full_wrap");
        drive(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, "all_prop");
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_max");
        drive(1'b0, 32'h8000_0000, 32'h8000_0000, "msb_carry");
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, "reset_override");
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset_hold");
        drive(1'b0, 32'h0000_0001, 32'h7FFF_FFFF, "first_after_reset");
        drive(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, "alt_prop");
        drive(1'b0, 32'h0000_000F, 32'h0000_0001, "block_carry");

        for (int i = 0; i < 10000; i++) begin
            ra = pick();
            rb = pick();
            rr = ($urandom_range(0, 127) == 0);
            drive(rr, ra, rb, "random");
        end

        @(negedge clk);
        rst = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0",
                     exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
